// File: rtl/pc_gen_ras.sv
// rtl/pc_gen_ras.sv - fetch-stage PC generator with a circular return-address stack
module pc_gen_ras #(
    parameter int unsigned     PC_WIDTH     = 32,
    parameter logic [63:0]     RESET_VECTOR = 64'h0,
    parameter logic [63:0]     EXC_VECTOR   = 64'h0000_0080,
    parameter int unsigned     PC_INC       = 4,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stall_i,
    input  logic                exc_i,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    input  logic                call_i,
    input  logic                jump_i,
    input  logic [PC_WIDTH-1:0] target_i,
    input  logic                ret_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                pc_valid_o,
    output logic                ras_empty_o,
    output logic                ras_full_o,
    output logic                ras_ovf_o,
    output logic                ras_unf_o
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

    localparam logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_VECTOR);
    localparam logic [PC_WIDTH-1:0] EXC_PC   = PC_WIDTH'(EXC_VECTOR);
    localparam logic [PC_WIDTH-1:0] INC      = PC_WIDTH'(PC_INC);
    localparam logic [CW-1:0]       DEPTH    = CW'(RAS_DEPTH);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                valid_q, valid_d;
    logic [PW-1:0]       top_q, top_d;
    logic [CW-1:0]       count_q, count_d;
    logic                ovf_d, unf_d;
    logic                push;
    logic [PC_WIDTH-1:0] seq_pc;
    logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];

    // Natural-width add: carry out of the top bit is discarded, giving modulo wrap.
    assign seq_pc = pc_q + INC;

    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        top_d   = top_q;
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        push    = 1'b0;

        if (!valid_q) begin
            valid_d = 1'b1;
        end else if (exc_i) begin
            pc_d = EXC_PC;
        end else if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (ret_i) begin
            if (count_q != '0) begin
                pc_d    = ras_q[top_q];
                top_d   = top_q - PW'(1);
                count_d = count_q - CW'(1);
            end else begin
                pc_d  = seq_pc;
                unf_d = 1'b1;
            end
        end else if (call_i) begin
            pc_d  = target_i;
            push  = 1'b1;
            top_d = top_q + PW'(1);
            // When full, the advancing pointer lands on the oldest entry and overwrites it.
            if (count_q == DEPTH) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (jump_i) begin
            pc_d = target_i;
        end else begin
            pc_d = seq_pc;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q        <= RESET_PC;
            valid_q     <= 1'b0;
            top_q       <= '0;
            count_q     <= '0;
            ras_empty_o <= 1'b1;
            ras_full_o  <= 1'b0;
            ras_ovf_o   <= 1'b0;
            ras_unf_o   <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            top_q       <= top_d;
            count_q     <= count_d;
            ras_empty_o <= (count_d == '0);
            ras_full_o  <= (count_d == DEPTH);
            ras_ovf_o   <= ovf_d;
            ras_unf_o   <= unf_d;
            if (push) begin
                ras_q[top_d] <= seq_pc;
            end
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = valid_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
// tb/tb_pc_gen_ras.sv - scoreboard bench for pc_gen_ras with directed vectors
module tb_pc_gen_ras;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, exc, redirect, call, jump, ret;
    logic [31:0] redirect_pc, target;
    logic [31:0] pc;
    logic        pc_valid, ras_empty, ras_full, ras_ovf, ras_unf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        valid;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb[$];

    pc_gen_ras dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .stall_i      (stall),
        .exc_i        (exc),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .call_i       (call),
        .jump_i       (jump),
        .target_i     (target),
        .ret_i        (ret),
        .pc_o         (pc),
        .pc_valid_o   (pc_valid),
        .ras_empty_o  (ras_empty),
        .ras_full_o   (ras_full),
        .ras_ovf_o    (ras_ovf),
        .ras_unf_o    (ras_unf)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input exp_t e);
        checks++;
        if (pc !== e.pc || pc_valid !== e.valid || ras_empty !== e.empty ||
            ras_full !== e.full || ras_ovf !== e.ovf || ras_unf !== e.unf) begin
            errors++;
            $display("FAIL %s: got pc=%h v=%b e=%b f=%b o=%b u=%b want pc=%h v=%b e=%b f=%b o=%b u=%b",
                     name, pc, pc_valid, ras_empty, ras_full, ras_ovf, ras_unf,
                     e.pc, e.valid, e.empty, e.full, e.ovf, e.unf);
        end
    endtask

    // Monitor: every expectation pushed at an edge is checked at the following falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                compare(e.name, e);
            end
        end
    end

    // Drive one cycle of request inputs and queue the state expected after the edge.
    task automatic cyc(input string name,
                       input logic s, input logic x, input logic rd, input logic [31:0] rdpc,
                       input logic c, input logic j, input logic [31:0] tg, input logic r,
                       input logic [31:0] epc, input logic ee, input logic ef,
                       input logic eo, input logic eu);
        exp_t e;
        stall = s; exc = x; redirect = rd; redirect_pc = rdpc;
        call = c; jump = j; target = tg; ret = r;
        @(posedge clk);
        e.name = name; e.pc = epc; e.valid = 1'b1;
        e.empty = ee; e.full = ef; e.ovf = eo; e.unf = eu;
        sb.push_back(e);
        #2;
    endtask

    task automatic check_reset(input string name);
        exp_t e;
        e.name = name; e.pc = 32'h0; e.valid = 1'b0;
        e.empty = 1'b1; e.full = 1'b0; e.ovf = 1'b0; e.unf = 1'b0;
        compare(name, e);
    endtask

    initial begin
        rst = 1'b1;
        stall = 0; exc = 0; redirect = 0; call = 0; jump = 0; ret = 0;
        redirect_pc = '0; target = '0;
        repeat (3) @(posedge clk);
        #2;
        check_reset("reset_state");
        rst = 1'b0;

        // run-up after reset
        cyc("first_edge",  0,0,0,0, 0,0,0,0, 32'h0,  1,0,0,0);
        cyc("seq_4",       0,0,0,0, 0,0,0,0, 32'h4,  1,0,0,0);
        cyc("seq_8",       0,0,0,0, 0,0,0,0, 32'h8,  1,0,0,0);
        cyc("seq_c",       0,0,0,0, 0,0,0,0, 32'hC,  1,0,0,0);
        cyc("seq_10",      0,0,0,0, 0,0,0,0, 32'h10, 1,0,0,0);

        // stall, override by redirect and exception; stall masks call/ret
        cyc("stall_1",     1,0,0,0, 0,0,0,0, 32'h10, 1,0,0,0);
        cyc("stall_2",     1,0,0,0, 1,0,32'h44,0, 32'h10, 1,0,0,0);
        cyc("stall_3",     1,0,0,0, 0,0,0,1, 32'h10, 1,0,0,0);
        cyc("stall_redir", 1,0,1,32'h200, 0,0,0,0, 32'h200, 1,0,0,0);
        cyc("exc_redir",   1,1,1,32'h300, 0,0,0,0, 32'h80, 1,0,0,0);

        // nested call/return
        cyc("to_100",      0,0,1,32'h100, 0,0,0,0, 32'h100, 1,0,0,0);
        cyc("call_400",    0,0,0,0, 1,0,32'h400,0, 32'h400, 0,0,0,0);
        cyc("call_800",    0,0,0,0, 1,0,32'h800,0, 32'h800, 0,0,0,0);
        cyc("ret_404",     0,0,0,0, 0,0,0,1, 32'h404, 0,0,0,0);
        cyc("ret_104",     0,0,0,0, 0,0,0,1, 32'h104, 1,0,0,0);

        // overflow and underflow with depth 4
        cyc("to_1000",     0,0,1,32'h1000, 0,0,0,0, 32'h1000, 1,0,0,0);
        cyc("ovf_call1",   0,0,0,0, 1,0,32'h2000,0, 32'h2000, 0,0,0,0);
        cyc("ovf_call2",   0,0,0,0, 1,0,32'h3000,0, 32'h3000, 0,0,0,0);
        cyc("ovf_call3",   0,0,0,0, 1,0,32'h4000,0, 32'h4000, 0,0,0,0);
        cyc("ovf_call4",   0,0,0,0, 1,0,32'h5000,0, 32'h5000, 0,1,0,0);
        cyc("ovf_call5",   0,0,0,0, 1,0,32'h6000,0, 32'h6000, 0,1,1,0);
        cyc("ovf_ret1",    0,0,0,0, 0,0,0,1, 32'h5004, 0,0,0,0);
        cyc("ovf_ret2",    0,0,0,0, 0,0,0,1, 32'h4004, 0,0,0,0);
        cyc("ovf_ret3",    0,0,0,0, 0,0,0,1, 32'h3004, 0,0,0,0);
        cyc("ovf_ret4",    0,0,0,0, 0,0,0,1, 32'h2004, 1,0,0,0);
        cyc("unf_ret5",    0,0,0,0, 0,0,0,1, 32'h2008, 1,0,0,1);
        cyc("unf_clear",   0,0,0,0, 0,0,0,0, 32'h200C, 1,0,0,0);

        // wrap and simultaneous call+ret on an empty stack
        cyc("to_top",      0,0,1,32'hFFFF_FFFC, 0,0,0,0, 32'hFFFF_FFFC, 1,0,0,0);
        cyc("wrap",        0,0,0,0, 0,0,0,0, 32'h0, 1,0,0,0);
        cyc("call_ret",    0,0,0,0, 1,0,32'h500,1, 32'h4, 1,0,0,1);
        cyc("after_cr",    0,0,0,0, 0,0,0,0, 32'h8, 1,0,0,0);

        // jump vs call priority
        cyc("jump_900",    0,0,0,0, 0,1,32'h900,0, 32'h900, 1,0,0,0);
        cyc("call_jump",   0,0,0,0, 1,1,32'h700,0, 32'h700, 0,0,0,0);
        cyc("ret_904",     0,0,0,0, 0,0,0,1, 32'h904, 1,0,0,0);

        // asynchronous reset in the middle of a call sequence
        cyc("pre_rst_call",0,0,0,0, 1,0,32'h300,0, 32'h300, 0,0,0,0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset("async_reset");
        @(posedge clk);
        #2;
        check_reset("held_reset");
        rst = 1'b0;
        cyc("post_rst_1",  0,0,0,0, 0,0,0,0, 32'h0, 1,0,0,0);
        cyc("post_rst_2",  0,0,0,0, 0,0,0,0, 32'h4, 1,0,0,0);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
